mem_stream_reader: RTL and testbench

- Read-side initiator for the team's synchronous-read dual-port RAM (registered read, 1-cycle latency, raddr sampled at posedge).
- Accepts a command (start address, length), issues sequential reads on the RAM read port, and emits the words as a valid/ready stream.
- A 2-entry output buffer absorbs read latency under backpressure, so the stream sustains 1 beat/cycle.

---
 rtl/mem_stream_reader.sv | 154 +++++++++++++++
 tb/tb_mem_stream_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Sequential-read initiator for a 1-cycle-latency synchronous RAM; emits a valid/ready stream.
// Optional running XOR checksum output is enabled by defining MEM_READER_XSUM_EN.
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef MEM_READER_XSUM_EN
  ,output logic [DATA_WIDTH-1:0] xsum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic       accept, issue, push, pop, credit_ok;
  logic [2:0] occupancy;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign mem_raddr = rd_ptr_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf0_q;
  assign out_last  = out_valid && (beats_left_q == LEN_WIDTH'(1));
  assign done      = done_q;
  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;

  // A pop frees a slot on the same edge, so only net occupancy after the pop matters.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign credit_ok = (occupancy - {2'b00, pop}) <= 3'd1;
  assign issue     = (state_q == S_READ) && (remaining_q != '0) && credit_ok;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    inflight_d   = issue;
    done_d       = 1'b0;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    count_d      = count_q;

    if (pop) beats_left_d = beats_left_q - LEN_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_ptr_d     = cmd_addr;
          remaining_d  = cmd_len;
          beats_left_d = cmd_len;
          state_d      = (cmd_len == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beats_left_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Two-entry FIFO with buf0 as head; simultaneous push/pop keeps order.
    if (push && pop) begin
      if (count_q == 2'd1) begin
        buf0_d = mem_rdata;
      end else begin
        buf0_d = buf1_q;
        buf1_d = mem_rdata;
      end
    end else if (pop) begin
      buf0_d  = buf1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) buf0_d = mem_rdata;
      else                 buf1_d = mem_rdata;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      count_q      <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      count_q      <= count_d;
      done_q       <= done_d;
    end
  end

`ifdef MEM_READER_XSUM_EN
  logic [DATA_WIDTH-1:0] xsum_q, xsum_d;

  always_comb begin
    xsum_d = xsum_q;
    if (accept)   xsum_d = '0;
    else if (pop) xsum_d = xsum_q ^ buf0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xsum_q <= '0;
    else     xsum_q <= xsum_d;
  end

  assign xsum = xsum_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a behavioural synchronous-read RAM.
// Define MEM_READER_XSUM_EN for both files to also exercise the checksum output.
module tb_mem_stream_reader;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef MEM_READER_XSUM_EN
  logic [DW-1:0] xsum;
`endif

  mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef MEM_READER_XSUM_EN
    , .xsum(xsum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  bit bp_mode  = 1'b0;

  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) out_ready = (cyc % 3 == 0);
    else         out_ready = 1'b1;
  endtask

  // Monitor: a beat is committed when valid&ready is seen mid-cycle.
  bit          prev_stall = 1'b0;
  logic [DW:0] prev_beat;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_beat", 32'({out_last, out_data}), 32'(prev_beat));
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e[DW-1:0]));
          check("beat_last", 32'(out_last), 32'(e[DW]));
        end
      end
    end
  end

  task automatic do_cmd(input logic [AW-1:0] addr, input int len);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = addr + AW'(i);
      exp_q.push_back({(i == len - 1), mem[a]});
    end
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int exp_cycles);
    int w;
    int d0;
    d0 = done_cnt;
    w  = 0;
    while (!done && w < 400) begin tick(); w++; end
    check("done_seen", 32'(done), 32'd1);
    if (exp_cycles >= 0) check("done_latency", 32'(cyc - acc_cyc), 32'(exp_cycles));
    check("idle_at_done", 32'(busy), 32'd0);
    tick();
    check("done_pulse_width", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int b0;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i & 'hF);
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic burst with latency checks
    do_cmd(8'h10, 4);
    check("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("first_valid_latency", 32'(k), 32'd2);
    wait_done(7);

    // Address wrap
    do_cmd(8'hFE, 4);
    check("raddr0", 32'(mem_raddr), 32'hFE);
    tick(); check("raddr1", 32'(mem_raddr), 32'hFF);
    tick(); check("raddr2", 32'(mem_raddr), 32'h00);
    tick(); check("raddr3", 32'(mem_raddr), 32'h01);
    wait_done(7);

    // Backpressure
    bp_mode = 1'b1;
    b0 = beat_cnt;
    do_cmd(8'h40, 8);
    wait_done(-1);
    check("bp_beats", 32'(beat_cnt - b0), 32'd8);
    bp_mode = 1'b0;
    tick();

    // Zero-length command
    b0 = beat_cnt;
    do_cmd(8'h55, 0);
    check("len0_busy", 32'(cmd_ready), 32'd0);
    check("len0_valid", 32'(out_valid), 32'd0);
    wait_done(1);
    check("len0_beats", 32'(beat_cnt - b0), 32'd0);

    // Reset mid-burst
    b0 = beat_cnt;
    do_cmd(8'h00, 6);
    k = 0;
    while ((beat_cnt - b0) < 2 && k < 50) begin tick(); k++; end
    check("midburst_reached", 32'(beat_cnt - b0), 32'd2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_raddr", 32'(mem_raddr), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    d0 = done_cnt;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    do_cmd(8'h20, 2);
    wait_done(5);

`ifdef MEM_READER_XSUM_EN
    do_cmd(8'h11, 1);
    wait_done(4);
    check("xsum_single", 32'(xsum), 32'h1);
    tick(); tick();
    check("xsum_hold", 32'(xsum), 32'h1);
    mem[8'h30] = 4'h3; mem[8'h31] = 4'h5; mem[8'h32] = 4'h6;
    do_cmd(8'h30, 3);
    check("xsum_clear", 32'(xsum), 32'h0);
    wait_done(6);
    check("xsum_final", 32'(xsum), 32'h0);
`endif

    tick(); tick();
    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
